// File: rtl/vend_pkg.sv
// vend_pkg
//   Shared types and constants for the parametrised vending controller.
//   - vend_state_t : controller state encoding (IDLE, CHECK, COLLECT, VEND, REFUND)
//   - DEF_*        : default widths of the credit and stock datapaths
//   - sat_max()    : all-ones value of a given width, used as a saturation limit
package vend_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_CHECK   = 3'd1,
        ST_COLLECT = 3'd2,
        ST_VEND    = 3'd3,
        ST_REFUND  = 3'd4
    } vend_state_t;

    localparam int DEF_CREDIT_W = 6;
    localparam int DEF_STOCK_W  = 4;

    function automatic int sat_max(input int width);
        return (1 << width) - 1;
    endfunction

    localparam int DEF_CREDIT_MAX = sat_max(DEF_CREDIT_W);
    localparam int DEF_STOCK_MAX  = sat_max(DEF_STOCK_W);

endpackage

// File: rtl/vend_stock.sv
// vend_stock
//   Array of NUM_ITEMS stock counters, one per item slot.
//   Ports:
//     clk, rst          : clock, asynchronous active-low reset (clears every counter)
//     i_restock_valid   : add i_restock_qty to slot i_restock_idx this cycle
//     i_restock_idx     : slot to restock (out-of-range index is ignored)
//     i_restock_qty     : quantity added, result saturates at all-ones
//     i_dec_valid       : remove one item from slot i_dec_idx this cycle
//     i_dec_idx         : slot to decrement
//     o_sold_out        : bit i set when slot i holds zero items (combinational)
module vend_stock #(
    parameter int NUM_ITEMS = 4,
    parameter int IDX_W     = $clog2(NUM_ITEMS),
    parameter int STOCK_W   = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_restock_valid,
    input  logic [IDX_W-1:0]     i_restock_idx,
    input  logic [STOCK_W-1:0]   i_restock_qty,
    input  logic                 i_dec_valid,
    input  logic [IDX_W-1:0]     i_dec_idx,
    output logic [NUM_ITEMS-1:0] o_sold_out
);

    logic [STOCK_W-1:0] r_stock [NUM_ITEMS];
    logic [STOCK_W:0]   w_sum   [NUM_ITEMS];
    logic [STOCK_W-1:0] w_next  [NUM_ITEMS];

    // Restock and decrement on the same slot combine into one update:
    // add first in a one-bit-wider sum, take one away, then saturate.
    always_comb begin
        for (int i = 0; i < NUM_ITEMS; i++) begin
            w_sum[i] = {1'b0, r_stock[i]};
            if (i_restock_valid && (i_restock_idx == IDX_W'(i)))
                w_sum[i] = w_sum[i] + {1'b0, i_restock_qty};
            if (i_dec_valid && (i_dec_idx == IDX_W'(i)) && (w_sum[i] != '0))
                w_sum[i] = w_sum[i] - (STOCK_W+1)'(1);
            w_next[i] = w_sum[i][STOCK_W] ? '1 : w_sum[i][STOCK_W-1:0];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NUM_ITEMS; i++) r_stock[i] <= '0;
        end else begin
            for (int i = 0; i < NUM_ITEMS; i++) r_stock[i] <= w_next[i];
        end
    end

    always_comb begin
        o_sold_out = '0;
        for (int i = 0; i < NUM_ITEMS; i++) o_sold_out[i] = (r_stock[i] == '0);
    end

endmodule

// File: rtl/vending_machine_param.sv
// vending_machine_param
//   Parametrised vending controller: selection, coin collection with overflow
//   rejection, dispense with change, cancel/timeout refund, per-slot stock.
//   All strobe inputs (sel_valid, coin_valid, cnl, restock_valid) are single-cycle
//   requests sampled on the rising clock edge; there is no back-pressure, so a
//   request that cannot be honoured is answered by a pulse (coin_rej, sel_err)
//   or simply ignored (cnl outside COLLECT, sel_valid outside IDLE).
//   Ports:
//     clk, rst                 : clock, asynchronous active-low reset
//     sel_valid, sel_idx       : item selection, price[sel_idx] captured with it
//     coin_valid, coin_value   : coin inserted (value 0 ignored)
//     cnl                      : cancel, refunds the collected credit
//     price                    : flattened price table, CREDIT_W bits per slot
//     restock_valid/idx/qty    : add stock to a slot, accepted in any state
//     pdt, pdt_idx, cng        : dispense pulse, slot and change (registered)
//     rtn_valid, rtn           : refund pulse and amount (registered)
//     coin_rej, sel_err        : rejection pulses (registered)
//     busy                     : state is not IDLE (decoded)
//     sold_out                 : per-slot empty flags (combinational)
module vending_machine_param
    import vend_pkg::*;
#(
    parameter int NUM_ITEMS = 4,
    parameter int IDX_W     = $clog2(NUM_ITEMS),
    parameter int CREDIT_W  = 6,
    parameter int COIN_W    = 3,
    parameter int STOCK_W   = 4,
    parameter int TIMEOUT   = 64
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          sel_valid,
    input  logic [IDX_W-1:0]              sel_idx,
    input  logic                          coin_valid,
    input  logic [COIN_W-1:0]             coin_value,
    input  logic                          cnl,
    input  logic [NUM_ITEMS*CREDIT_W-1:0] price,
    input  logic                          restock_valid,
    input  logic [IDX_W-1:0]              restock_idx,
    input  logic [STOCK_W-1:0]            restock_qty,
    output logic                          pdt,
    output logic [IDX_W-1:0]              pdt_idx,
    output logic [CREDIT_W-1:0]           cng,
    output logic [CREDIT_W-1:0]           rtn,
    output logic                          rtn_valid,
    output logic                          coin_rej,
    output logic                          sel_err,
    output logic                          busy,
    output logic [NUM_ITEMS-1:0]          sold_out
);

    localparam int TIMER_W = $clog2(TIMEOUT);
    localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(TIMEOUT - 1);

    vend_state_t          r_state;
    logic [IDX_W-1:0]     r_idx;
    logic [CREDIT_W-1:0]  r_price;
    logic [CREDIT_W-1:0]  r_credit;
    logic [TIMER_W-1:0]   r_timer;
    logic                 r_pdt;
    logic [IDX_W-1:0]     r_pdt_idx;
    logic [CREDIT_W-1:0]  r_cng;
    logic [CREDIT_W-1:0]  r_rtn;
    logic                 r_rtn_valid;
    logic                 r_coin_rej;
    logic                 r_sel_err;

    logic [CREDIT_W-1:0]  w_sel_price;
    logic                 w_in_stock;
    logic                 w_coin;
    logic [CREDIT_W:0]    w_sum;
    logic                 w_dec;
    logic [NUM_ITEMS-1:0] w_sold_out;

    // Price mux and stock lookup; an index beyond the last slot matches
    // nothing, so it reads price 0 and "not in stock".
    always_comb begin
        w_sel_price = '0;
        w_in_stock  = 1'b0;
        for (int i = 0; i < NUM_ITEMS; i++) begin
            if (sel_idx == IDX_W'(i)) w_sel_price = price[i*CREDIT_W +: CREDIT_W];
            if (r_idx == IDX_W'(i))   w_in_stock  = !w_sold_out[i];
        end
    end

    assign w_coin = coin_valid && (coin_value != '0);
    // One extra bit so an overflowing coin is detected instead of wrapping.
    assign w_sum  = {1'b0, r_credit} + (CREDIT_W+1)'(coin_value);
    assign w_dec  = (r_state == ST_VEND);

    vend_stock #(
        .NUM_ITEMS (NUM_ITEMS),
        .IDX_W     (IDX_W),
        .STOCK_W   (STOCK_W)
    ) u_stock (
        .clk             (clk),
        .rst             (rst),
        .i_restock_valid (restock_valid),
        .i_restock_idx   (restock_idx),
        .i_restock_qty   (restock_qty),
        .i_dec_valid     (w_dec),
        .i_dec_idx       (r_idx),
        .o_sold_out      (w_sold_out)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= ST_IDLE;
            r_idx       <= '0;
            r_price     <= '0;
            r_credit    <= '0;
            r_timer     <= '0;
            r_pdt       <= 1'b0;
            r_pdt_idx   <= '0;
            r_cng       <= '0;
            r_rtn       <= '0;
            r_rtn_valid <= 1'b0;
            r_coin_rej  <= 1'b0;
            r_sel_err   <= 1'b0;
        end else begin
            r_pdt       <= 1'b0;
            r_rtn_valid <= 1'b0;
            r_coin_rej  <= 1'b0;
            r_sel_err   <= 1'b0;

            // Coins are only credited in COLLECT; anywhere else they go back.
            if (w_coin && (r_state != ST_COLLECT)) r_coin_rej <= 1'b1;

            case (r_state)
                ST_IDLE: begin
                    if (sel_valid) begin
                        r_idx   <= sel_idx;
                        r_price <= w_sel_price;
                        r_state <= ST_CHECK;
                    end
                end
                ST_CHECK: begin
                    if (w_in_stock) begin
                        r_credit <= '0;
                        r_timer  <= '0;
                        r_state  <= ST_COLLECT;
                    end else begin
                        r_sel_err <= 1'b1;
                        r_state   <= ST_IDLE;
                    end
                end
                ST_COLLECT: begin
                    if (cnl) begin
                        // A coin arriving with the cancel is not credited.
                        if (w_coin) r_coin_rej <= 1'b1;
                        r_state <= ST_REFUND;
                    end else if (w_coin) begin
                        if (w_sum[CREDIT_W]) begin
                            r_coin_rej <= 1'b1;
                            if (r_timer != TIMER_LAST) r_timer <= r_timer + 1'b1;
                        end else begin
                            r_credit <= w_sum[CREDIT_W-1:0];
                            r_timer  <= '0;
                            if (w_sum[CREDIT_W-1:0] >= r_price) r_state <= ST_VEND;
                        end
                    end else if (r_credit >= r_price) begin
                        // Reached only for a zero price.
                        r_state <= ST_VEND;
                    end else if (r_timer == TIMER_LAST) begin
                        r_state <= ST_REFUND;
                    end else begin
                        r_timer <= r_timer + 1'b1;
                    end
                end
                ST_VEND: begin
                    r_pdt     <= 1'b1;
                    r_pdt_idx <= r_idx;
                    r_cng     <= r_credit - r_price;
                    r_state   <= ST_IDLE;
                end
                ST_REFUND: begin
                    r_rtn_valid <= 1'b1;
                    r_rtn       <= r_credit;
                    r_state     <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign pdt       = r_pdt;
    assign pdt_idx   = r_pdt_idx;
    assign cng       = r_cng;
    assign rtn       = r_rtn;
    assign rtn_valid = r_rtn_valid;
    assign coin_rej  = r_coin_rej;
    assign sel_err   = r_sel_err;
    assign busy      = (r_state != ST_IDLE);
    assign sold_out  = w_sold_out;

endmodule

// File: tb/tb_vending_machine_param.sv
// tb_vending_machine_param
//   Directed bench for vending_machine_param with 5 slots (so indices 5..7 are
//   out of range) and a 4-bit credit datapath (so the overflow boundary is 15).
//   Inputs change 1 time unit after a rising edge and outputs are checked there.
module tb_vending_machine_param;

    localparam int N   = 5;
    localparam int IW  = 3;
    localparam int CW  = 4;
    localparam int COW = 3;
    localparam int SW  = 4;
    localparam int TO  = 64;

    logic            clk = 1'b0;
    logic            rst;
    logic            sel_valid;
    logic [IW-1:0]   sel_idx;
    logic            coin_valid;
    logic [COW-1:0]  coin_value;
    logic            cnl;
    logic [N*CW-1:0] price;
    logic            restock_valid;
    logic [IW-1:0]   restock_idx;
    logic [SW-1:0]   restock_qty;
    logic            pdt;
    logic [IW-1:0]   pdt_idx;
    logic [CW-1:0]   cng;
    logic [CW-1:0]   rtn;
    logic            rtn_valid;
    logic            coin_rej;
    logic            sel_err;
    logic            busy;
    logic [N-1:0]    sold_out;

    int checks   = 0;
    int failures = 0;

    vending_machine_param #(
        .NUM_ITEMS (N),
        .IDX_W     (IW),
        .CREDIT_W  (CW),
        .COIN_W    (COW),
        .STOCK_W   (SW),
        .TIMEOUT   (TO)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .sel_valid     (sel_valid),
        .sel_idx       (sel_idx),
        .coin_valid    (coin_valid),
        .coin_value    (coin_value),
        .cnl           (cnl),
        .price         (price),
        .restock_valid (restock_valid),
        .restock_idx   (restock_idx),
        .restock_qty   (restock_qty),
        .pdt           (pdt),
        .pdt_idx       (pdt_idx),
        .cng           (cng),
        .rtn           (rtn),
        .rtn_valid     (rtn_valid),
        .coin_rej      (coin_rej),
        .sel_err       (sel_err),
        .busy          (busy),
        .sold_out      (sold_out)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic set_price(input int idx, input logic [CW-1:0] v);
        price[idx*CW +: CW] = v;
    endtask

    task automatic restock(input logic [IW-1:0] idx, input logic [SW-1:0] qty);
        restock_valid = 1'b1;
        restock_idx   = idx;
        restock_qty   = qty;
        tick();
        restock_valid = 1'b0;
    endtask

    task automatic do_select(input logic [IW-1:0] idx);
        sel_valid = 1'b1;
        sel_idx   = idx;
        tick();
        sel_valid = 1'b0;
    endtask

    task automatic do_coin(input logic [COW-1:0] v);
        coin_valid = 1'b1;
        coin_value = v;
        tick();
        coin_valid = 1'b0;
        coin_value = '0;
    endtask

    // Zero-price purchase: CHECK, COLLECT, VEND, then pdt is visible.
    task automatic vend_free(input logic [IW-1:0] idx);
        do_select(idx);
        tick();
        tick();
        chk("free_pdt_early", 32'(pdt), 0);
        tick();
        chk("free_pdt", 32'(pdt), 1);
        chk("free_pdt_idx", 32'(pdt_idx), 32'(idx));
        chk("free_cng", 32'(cng), 0);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        rst           = 1'b0;
        sel_valid     = 1'b0;
        sel_idx       = '0;
        coin_valid    = 1'b0;
        coin_value    = '0;
        cnl           = 1'b0;
        price         = '0;
        restock_valid = 1'b0;
        restock_idx   = '0;
        restock_qty   = '0;

        tick();
        tick();
        chk("rst_busy", 32'(busy), 0);
        chk("rst_pdt", 32'(pdt), 0);
        chk("rst_rtn_valid", 32'(rtn_valid), 0);
        chk("rst_cng", 32'(cng), 0);
        chk("rst_rtn", 32'(rtn), 0);
        chk("rst_sold_out", 32'(sold_out), 32'h1f);
        rst = 1'b1;
        tick();

        // Coin while idle is returned.
        do_coin(3'd4);
        chk("idle_coin_rej", 32'(coin_rej), 1);
        chk("idle_coin_busy", 32'(busy), 0);
        tick();
        chk("idle_coin_rej_end", 32'(coin_rej), 0);

        // Basic purchase with change: price 3, coins 2+2.
        restock(3'd0, 4'd3);
        chk("restock0_sold_out", 32'(sold_out[0]), 0);
        set_price(0, 4'd3);
        do_select(3'd0);
        chk("buy_busy_check", 32'(busy), 1);
        tick();
        do_coin(3'd2);
        do_coin(3'd2);
        chk("buy_pdt_early", 32'(pdt), 0);
        chk("buy_busy_vend", 32'(busy), 1);
        tick();
        chk("buy_pdt", 32'(pdt), 1);
        chk("buy_pdt_idx", 32'(pdt_idx), 0);
        chk("buy_cng", 32'(cng), 1);
        chk("buy_busy_done", 32'(busy), 0);
        tick();
        chk("buy_pdt_pulse", 32'(pdt), 0);
        chk("buy_cng_hold", 32'(cng), 1);

        // Sold-out slot.
        do_select(3'd2);
        chk("soldout_busy", 32'(busy), 1);
        chk("soldout_err_early", 32'(sel_err), 0);
        tick();
        chk("soldout_sel_err", 32'(sel_err), 1);
        chk("soldout_busy_drop", 32'(busy), 0);
        tick();
        chk("soldout_err_pulse", 32'(sel_err), 0);

        // Index beyond the last slot.
        do_select(3'd6);
        tick();
        chk("badidx_sel_err", 32'(sel_err), 1);
        chk("badidx_busy", 32'(busy), 0);

        // Cancel after one coin.
        restock(3'd1, 4'd1);
        set_price(1, 4'd5);
        do_select(3'd1);
        tick();
        do_coin(3'd2);
        cnl = 1'b1;
        tick();
        cnl = 1'b0;
        chk("cancel_rtn_early", 32'(rtn_valid), 0);
        chk("cancel_busy", 32'(busy), 1);
        tick();
        chk("cancel_rtn_valid", 32'(rtn_valid), 1);
        chk("cancel_rtn", 32'(rtn), 2);
        chk("cancel_no_pdt", 32'(pdt), 0);
        tick();
        chk("cancel_rtn_pulse", 32'(rtn_valid), 0);
        chk("cancel_rtn_hold", 32'(rtn), 2);

        // Credit overflow at the 4-bit boundary: 7+7 accepted, third 7 rejected.
        restock(3'd3, 4'd1);
        set_price(3, 4'd15);
        do_select(3'd3);
        tick();
        do_coin(3'd7);
        chk("ovf_first_ok", 32'(coin_rej), 0);
        do_coin(3'd7);
        do_coin(3'd7);
        chk("ovf_coin_rej", 32'(coin_rej), 1);
        chk("ovf_busy", 32'(busy), 1);
        do_coin(3'd1);
        chk("ovf_rej_pulse", 32'(coin_rej), 0);
        chk("ovf_pdt_early", 32'(pdt), 0);
        tick();
        chk("ovf_pdt", 32'(pdt), 1);
        chk("ovf_pdt_idx", 32'(pdt_idx), 3);
        chk("ovf_cng", 32'(cng), 0);
        chk("ovf_sold_out3", 32'(sold_out[3]), 1);

        // Inactivity timeout: refund appears TIMEOUT+1 edges after the last coin.
        do_select(3'd1);
        tick();
        do_coin(3'd1);
        for (int k = 0; k < TO; k++) begin
            tick();
            chk("timeout_wait", 32'(rtn_valid), 0);
        end
        chk("timeout_busy", 32'(busy), 1);
        tick();
        chk("timeout_rtn_valid", 32'(rtn_valid), 1);
        chk("timeout_rtn", 32'(rtn), 1);
        chk("timeout_no_pdt", 32'(pdt), 0);

        // Full slot restocked in the same cycle it vends: stays at 15.
        restock(3'd4, 4'd15);
        set_price(4, 4'd2);
        do_select(3'd4);
        tick();
        do_coin(3'd2);
        restock(3'd4, 4'd5);
        chk("sat_pdt", 32'(pdt), 1);
        chk("sat_pdt_idx", 32'(pdt_idx), 4);
        set_price(4, 4'd0);
        for (int k = 0; k < 14; k++) vend_free(3'd4);
        chk("sat_left_one", 32'(sold_out[4]), 0);
        vend_free(3'd4);
        chk("sat_empty", 32'(sold_out[4]), 1);

        // Slot 0 had 3, one sold: two more free vends empty it.
        set_price(0, 4'd0);
        vend_free(3'd0);
        vend_free(3'd0);
        chk("slot0_empty", 32'(sold_out[0]), 1);
        do_select(3'd0);
        tick();
        chk("slot0_sel_err", 32'(sel_err), 1);

        // Reset in the middle of COLLECT.
        restock(3'd2, 4'd2);
        set_price(2, 4'd9);
        do_select(3'd2);
        tick();
        do_coin(3'd3);
        chk("midrst_busy_before", 32'(busy), 1);
        #2;
        rst = 1'b0;
        #1;
        chk("midrst_busy", 32'(busy), 0);
        chk("midrst_rtn", 32'(rtn), 0);
        chk("midrst_rtn_valid", 32'(rtn_valid), 0);
        chk("midrst_pdt", 32'(pdt), 0);
        chk("midrst_coin_rej", 32'(coin_rej), 0);
        chk("midrst_sold_out", 32'(sold_out), 32'h1f);
        tick();
        rst = 1'b1;
        tick();
        chk("midrst_no_refund", 32'(rtn_valid), 0);
        chk("midrst_idle", 32'(busy), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/vending_machine_param.md
# vending_machine_param

Parametrised vending controller: N item slots with per-slot runtime prices and stock counters, generic coin input, credit accumulation with overflow rejection, change, cancel refund and inactivity timeout. Replaces the fixed 4-item, 2-coin controller in the vending top level. It sits between the coin acceptor/keypad front end and the dispenser/coin-return actuators.

## Interface
- NUM_ITEMS, 4: number of item slots (2..16).
- IDX_W, $clog2(NUM_ITEMS): item index width.
- CREDIT_W, 6: credit, price and change width.
- COIN_W, 3: coin value width.
- STOCK_W, 4: per-slot stock counter width.
- TIMEOUT, 64: idle cycles in COLLECT before automatic refund (≥2).

- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-low.
- sel_valid  in  1  item selection strobe (1 cycle).
- sel_idx  in  IDX_W  selected slot.
- coin_valid  in  1  coin-inserted strobe.
- coin_value  in  COIN_W  value of inserted coin (0 ignored).
- cnl  in  1  cancel request.
- price  in  NUM_ITEMS*CREDIT_W  flattened price table, slot i at [i*CREDIT_W +: CREDIT_W]; sampled at selection.
- restock_valid  in  1  restock strobe.
- restock_idx  in  IDX_W  slot to restock.
- restock_qty  in  STOCK_W  quantity added.
- pdt  out  1  dispense pulse, 1 cycle.
- pdt_idx  out  IDX_W  slot dispensed, valid with pdt.
- cng  out  CREDIT_W  change amount, valid with pdt.
- rtn  out  CREDIT_W  refund amount, valid with rtn_valid.
- rtn_valid  out  1  refund pulse, 1 cycle.
- coin_rej  out  1  coin rejected pulse; coin must be physically returned.
- sel_err  out  1  selection rejected pulse (sold out or index ≥ NUM_ITEMS).
- busy  out  1  high whenever state ≠ IDLE.
- sold_out  out  NUM_ITEMS  bit i = stock[i]==0, combinational from stock.

## Operation
- States: IDLE, CHECK, COLLECT, VEND, REFUND.
- IDLE: sel_valid latches sel_idx and price[sel_idx] → CHECK. Coins in IDLE → coin_rej. cnl ignored.
- CHECK: index valid and stock>0 → COLLECT, credit=0, timer=0. Otherwise sel_err pulse → IDLE.
- COLLECT, priority cnl > coin > timeout:
  - cnl: → REFUND.
  - coin_valid, value≠0: if credit+value exceeds 2^CREDIT_W−1 → coin_rej, credit unchanged. Otherwise credit += value, timer=0. If new credit ≥ price → VEND.
  - timer reaches TIMEOUT−1 with no coin → REFUND.
  - sel_valid ignored (no reselection mid-transaction).
- Price 0: CHECK → COLLECT, and COLLECT goes to VEND on the next cycle with no coin.
- VEND: pdt=1, pdt_idx=latched idx, cng=credit−price, stock[idx]−1 → IDLE.
- REFUND: rtn_valid=1, rtn=credit (rtn_valid fires even when credit=0) → IDLE.
- Restock accepted in any state:
  - stock[restock_idx] += restock_qty, saturating at 2^STOCK_W−1.
  - Out-of-range idx ignored.
  - Same-cycle restock and vend decrement on one slot: net = stock+qty−1, saturated.
- Credit arithmetic uses a CREDIT_W+1 intermediate; no wrap-around.

## Timing
- All outputs registered except sold_out and busy (decoded from state).
- Reset values: state IDLE, credit 0, timer 0, pdt/rtn_valid/coin_rej/sel_err 0, cng/rtn/pdt_idx 0, every stock counter 0.
- Pulses last exactly one cycle. cng/rtn hold their value until the next pdt/rtn_valid.
- Latency: sel_valid → COLLECT in 2 cycles. Final coin → pdt in 2 cycles (COLLECT→VEND edge, then VEND registers pdt). cnl → rtn_valid in 2 cycles.
- Inputs are sampled on rising clk. Back-to-back coins every cycle are legal.
- Reset mid-transaction discards credit without rtn_valid; stock is cleared.

## Structure
- Package vend_pkg: state enum vend_state_t; helper localparams for saturation maxima.
- Sub-module vend_stock: NUM_ITEMS×STOCK_W counter array. Provides restock/decrement ports and sold_out output.
- Top holds the FSM, credit register, timer and price mux.

## Test plan
- Restock slot 0 qty 3, price0=3. Select 0, coins 2 then 2 → pdt, pdt_idx=0, cng=1, stock0=2.
- Slot 2 stock 0, select 2 → sel_err one cycle, busy drops after 2 cycles, no COLLECT.
- Price1=5. Select 1, coin 2, cnl → rtn_valid, rtn=2, no pdt.
- CREDIT_W=4, price=15. Coins 7,7,7 → third coin gives coin_rej with credit 14. Then coin 1 → pdt, cng=0.
- Select, coin 1, no further activity for TIMEOUT cycles → rtn_valid, rtn=1.
- Stock 15 (max), restock qty 5 in the same cycle as a vend from that slot → stock=15. Reset mid-COLLECT → all outputs 0, state IDLE.
